// File: rtl/pwm_fade_ctrl.sv
// Fade controller for four PWM duty registers (R, G, B, GEN): accepts
// valid/ready fade commands and ramps each channel one LSB per step.
module pwm_fade_ctrl #(
  parameter int DW       = 8,
  parameter int PRESCALE = 256,
  parameter bit PREEMPT  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_chan,
  input  logic [DW-1:0]   cmd_target,
  input  logic [7:0]      cmd_rate,
  input  logic            hold,
  output logic [4*DW-1:0] duty,
  output logic [3:0]      busy,
  output logic [3:0]      done
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  logic [PW-1:0] presc;
  logic          tick;
  logic          accept;

  state_t        state    [4];
  logic [DW-1:0] duty_q   [4];
  logic [DW-1:0] target_q [4];
  logic [7:0]    rate_q   [4];
  logic [7:0]    rate_cnt [4];
  logic [DW-1:0] step_duty[4];

  assign tick      = (presc == PS_LAST) && !hold;
  assign cmd_ready = PREEMPT || (state[cmd_chan] == IDLE);
  assign accept    = cmd_valid && cmd_ready && !rst;

  // Next duty one LSB toward the target; the compare keeps 0 and max as end stops.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      // NOTE: assign a default first so no path through this block leaves the value unassigned, which would infer a latch.
      step_duty[c] = duty_q[c];
      if (duty_q[c] < target_q[c])
        step_duty[c] = duty_q[c] + 1'b1;
      else if (duty_q[c] > target_q[c])
        step_duty[c] = duty_q[c] - 1'b1;
    end
  end

  // NOTE: all state uses non-blocking assignments so every channel reads the pre-edge values of its neighbours and the prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      for (int c = 0; c < 4; c++) begin
        // NOTE: these per-channel arrays are small register files, not RAM, so they are reset explicitly.
        state[c]    <= IDLE;
        duty_q[c]   <= '0;
        target_q[c] <= '0;
        rate_q[c]   <= '0;
        rate_cnt[c] <= '0;
        done[c]     <= 1'b0;
      end
    end else begin
      if (!hold)
        presc <= (presc == PS_LAST) ? '0 : presc + 1'b1;

      for (int c = 0; c < 4; c++) begin
        done[c] <= 1'b0;
        if (accept && (cmd_chan == 2'(c))) begin
          // A new command always wins over a step due on the same edge.
          target_q[c] <= cmd_target;
          rate_q[c]   <= cmd_rate;
          rate_cnt[c] <= '0;
          if ((cmd_target == duty_q[c]) || (cmd_rate == 8'd0)) begin
            duty_q[c] <= cmd_target;
            state[c]  <= IDLE;
            done[c]   <= 1'b1;
          end else begin
            state[c]  <= RAMP;
          end
        end else if ((state[c] == RAMP) && tick) begin
          if (rate_cnt[c] == rate_q[c] - 8'd1) begin
            rate_cnt[c] <= '0;
            duty_q[c]   <= step_duty[c];
            if (step_duty[c] == target_q[c]) begin
              state[c] <= IDLE;
              done[c]  <= 1'b1;
            end
          end else begin
            rate_cnt[c] <= rate_cnt[c] + 8'd1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign duty[g*DW +: DW] = duty_q[g];
    assign busy[g]          = (state[g] == RAMP);
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed self-checking bench for pwm_fade_ctrl with PRESCALE=4; instance u_dut0
// stalls commands to busy channels, u_dut1 preempts them.
module tb_pwm_fade_ctrl;

  localparam int DW = 8;
  localparam int PS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          hold;
  logic [1:0]    cmd_chan;
  logic [DW-1:0] cmd_target;
  logic [7:0]    cmd_rate;
  logic          valid0, valid1;
  logic          ready0, ready1;
  logic [31:0]   duty0, duty1;
  logic [3:0]    busy0, busy1, done0, done1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  pwm_fade_ctrl #(.DW(DW), .PRESCALE(PS), .PREEMPT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(valid0), .cmd_ready(ready0),
    .cmd_chan(cmd_chan), .cmd_target(cmd_target), .cmd_rate(cmd_rate),
    .hold(hold), .duty(duty0), .busy(busy0), .done(done0)
  );

  pwm_fade_ctrl #(.DW(DW), .PRESCALE(PS), .PREEMPT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(valid1), .cmd_ready(ready1),
    .cmd_chan(cmd_chan), .cmd_target(cmd_target), .cmd_rate(cmd_rate),
    .hold(hold), .duty(duty1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] duty_of(input int sel, input int ch);
    return (sel != 0) ? duty1[ch*8 +: 8] : duty0[ch*8 +: 8];
  endfunction

  function automatic logic busy_of(input int sel, input int ch);
    return (sel != 0) ? busy1[ch] : busy0[ch];
  endfunction

  function automatic logic done_of(input int sel, input int ch);
    return (sel != 0) ? done1[ch] : done0[ch];
  endfunction

  // Results of the most recent send / watch.
  int         acc_cyc, stall_n;
  logic       busy_at_rdy, busy_before_rdy;
  logic [7:0] duty_at_rdy;
  logic [7:0] chg_val[$];
  int         chg_cyc[$];
  int         done_cnt, done_cyc, both_hi, busy_cnt, first_idle;

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int sel, input int ch, input logic [7:0] tgt,
                      input logic [7:0] rate, input int budget);
    logic rdy;
    cmd_chan = 2'(ch); cmd_target = tgt; cmd_rate = rate;
    if (sel != 0) valid1 = 1'b1; else valid0 = 1'b1;
    acc_cyc = -1; stall_n = 0; busy_before_rdy = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      rdy = (sel != 0) ? ready1 : ready0;
      if (rdy) begin
        busy_at_rdy = busy_of(sel, ch);
        duty_at_rdy = duty_of(sel, ch);
        @(negedge clk);
        acc_cyc = cyc;
        break;
      end
      busy_before_rdy = busy_of(sel, ch);
      stall_n++;
      @(negedge clk);
    end
    valid0 = 1'b0; valid1 = 1'b0;
    if (acc_cyc < 0) check("send_timeout", 32'(stall_n), 32'(budget + 1));
  endtask

  // Samples from the current negedge for n cycles, recording duty changes and done/busy.
  task automatic watch(input int sel, input int ch, input logic [7:0] prev0, input int n);
    logic [7:0] prev = prev0;
    chg_val.delete(); chg_cyc.delete();
    done_cnt = 0; done_cyc = -1; both_hi = 0; busy_cnt = 0; first_idle = -1;
    for (int i = 0; i < n; i++) begin
      if (duty_of(sel, ch) != prev) begin
        prev = duty_of(sel, ch);
        chg_val.push_back(prev);
        chg_cyc.push_back(cyc);
      end
      if (done_of(sel, ch)) begin done_cnt++; done_cyc = cyc; end
      if (done_of(sel, ch) && busy_of(sel, ch)) both_hi++;
      if (busy_of(sel, ch)) busy_cnt++;
      else if (first_idle < 0) first_idle = cyc;
      @(negedge clk);
    end
  endtask

  task automatic wait_duty(input int sel, input int ch, input logic [7:0] val, input int budget);
    int k = 0;
    while ((duty_of(sel, ch) != val) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    if (duty_of(sel, ch) != val) check("wait_duty_timeout", 32'(duty_of(sel, ch)), 32'(val));
  endtask

  int n0_changes, k_off;

  initial begin
    rst = 1'b1; hold = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    cmd_chan = '0; cmd_target = '0; cmd_rate = '0;
    repeat (3) @(negedge clk);
    check("rst_duty", duty0, 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_done", 32'(done0), 32'h0);
    rst = 1'b0;

    // 1: ch0 0 -> 3, rate 1
    send(0, 0, 8'h03, 8'd1, 4);
    watch(0, 0, 8'h00, 20);
    check("t1_nsteps", 32'(chg_val.size()), 32'd3);
    if (chg_val.size() == 3) begin
      check("t1_v0", 32'(chg_val[0]), 32'd1);
      check("t1_v1", 32'(chg_val[1]), 32'd2);
      check("t1_v2", 32'(chg_val[2]), 32'd3);
      check("t1_first_le_ps", 32'(chg_cyc[0] - acc_cyc <= PS && chg_cyc[0] > acc_cyc), 32'd1);
      check("t1_gap0", 32'(chg_cyc[1] - chg_cyc[0]), 32'(PS));
      check("t1_gap1", 32'(chg_cyc[2] - chg_cyc[1]), 32'(PS));
      check("t1_done_at_end", 32'(done_cyc), 32'(chg_cyc[2]));
      check("t1_busy_until_end", 32'(first_idle), 32'(chg_cyc[2]));
    end
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_done_busy", 32'(both_hi), 32'd0);
    check("t1_others", {8'h0, duty0[31:8]}, 32'h0);

    // 2: ch2 jump to 0xF0, then ramp down to 0xEE at rate 2
    send(0, 2, 8'hF0, 8'd0, 4);
    check("t2_jump", 32'(duty_of(0, 2)), 32'hF0);
    check("t2_jump_done", 32'(done0[2]), 32'd1);
    send(0, 2, 8'hEE, 8'd2, 4);
    watch(0, 2, 8'hF0, 30);
    check("t2_nsteps", 32'(chg_val.size()), 32'd2);
    if (chg_val.size() == 2) begin
      check("t2_v0", 32'(chg_val[0]), 32'hEF);
      check("t2_v1", 32'(chg_val[1]), 32'hEE);
      check("t2_first_le", 32'(chg_cyc[0] - acc_cyc <= 2*PS && chg_cyc[0] > acc_cyc), 32'd1);
      check("t2_gap", 32'(chg_cyc[1] - chg_cyc[0]), 32'(2*PS));
      check("t2_done_at_end", 32'(done_cyc), 32'(chg_cyc[1]));
    end
    check("t2_done_cnt", 32'(done_cnt), 32'd1);

    // target equal to current duty completes immediately
    send(0, 2, 8'hEE, 8'd5, 4);
    check("teq_done", 32'(done0[2]), 32'd1);
    check("teq_busy", 32'(busy0[2]), 32'd0);
    check("teq_duty", 32'(duty_of(0, 2)), 32'hEE);

    // 3: ch1 rate 0 jump
    send(0, 1, 8'h80, 8'd0, 4);
    watch(0, 1, 8'h00, 5);
    check("t3_nchg", 32'(chg_val.size()), 32'd1);
    if (chg_val.size() == 1) begin
      check("t3_val", 32'(chg_val[0]), 32'h80);
      check("t3_when", 32'(chg_cyc[0]), 32'(acc_cyc));
    end
    check("t3_done_when", 32'(done_cyc), 32'(acc_cyc));
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    check("t3_never_busy", 32'(busy_cnt), 32'd0);

    // 4a: stalled second command to busy ch3
    send(0, 3, 8'h04, 8'd1, 4);
    check("t4a_busy", 32'(busy0[3]), 32'd1);
    send(0, 3, 8'h00, 8'd0, 40);
    check("t4a_stalled", 32'(stall_n > 0), 32'd1);
    check("t4a_busy_before", 32'(busy_before_rdy), 32'd1);
    check("t4a_busy_at_rdy", 32'(busy_at_rdy), 32'd0);
    check("t4a_duty_at_rdy", 32'(duty_at_rdy), 32'h04);
    check("t4a_duty_after", 32'(duty_of(0, 3)), 32'h00);
    check("t4a_done_after", 32'(done0[3]), 32'd1);

    // 4b: preempt ch3 on u_dut1 at duty 5, retarget to 2
    send(1, 3, 8'h10, 8'd1, 4);
    wait_duty(1, 3, 8'h05, 40);
    send(1, 3, 8'h02, 8'd1, 4);
    check("t4b_no_stall", 32'(stall_n), 32'd0);
    check("t4b_busy_at_rdy", 32'(busy_at_rdy), 32'd1);
    watch(1, 3, 8'h05, 30);
    check("t4b_nsteps", 32'(chg_val.size()), 32'd3);
    if (chg_val.size() == 3) begin
      check("t4b_v0", 32'(chg_val[0]), 32'd4);
      check("t4b_v1", 32'(chg_val[1]), 32'd3);
      check("t4b_v2", 32'(chg_val[2]), 32'd2);
      check("t4b_gap", 32'(chg_cyc[2] - chg_cyc[1]), 32'(PS));
    end
    check("t4b_done_cnt", 32'(done_cnt), 32'd1);
    check("t4b_done_busy", 32'(both_hi), 32'd0);

    // 5: hold for 20 cycles mid-ramp on ch0 (3 -> 0x0A)
    send(0, 0, 8'h0A, 8'd1, 4);
    wait_duty(0, 0, 8'h05, 40);
    @(negedge clk);
    hold = 1'b1;
    n0_changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (duty_of(0, 0) != 8'h05) n0_changes++;
      if (i == 5) begin
        cmd_chan = 2'd1; cmd_target = 8'h33; cmd_rate = 8'd0; valid1 = 1'b1;
      end
      if (i == 6) begin
        valid1 = 1'b0;
        check("t5_hold_accept", 32'(duty_of(1, 1)), 32'h33);
        check("t5_hold_done", 32'(done1[1]), 32'd1);
      end
    end
    hold = 1'b0;
    check("t5_frozen", 32'(n0_changes), 32'd0);
    k_off = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (duty_of(0, 0) != 8'h05) begin k_off = k; break; end
    end
    check("t5_resume_offset", 32'(k_off), 32'd3);
    check("t5_resume_val", 32'(duty_of(0, 0)), 32'h06);
    k_off = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (duty_of(0, 0) != 8'h06) begin k_off = k; break; end
    end
    check("t5_next_gap", 32'(k_off), 32'(PS));

    // 6: reset with all four channels ramping
    repeat (30) @(negedge clk);
    send(0, 0, 8'hFF, 8'd3, 4);
    send(0, 1, 8'h00, 8'd3, 4);
    send(0, 2, 8'h00, 8'd3, 4);
    send(0, 3, 8'hFF, 8'd3, 4);
    check("t6_all_busy", 32'(busy0), 32'hF);
    rst = 1'b1;
    @(negedge clk);
    check("t6_duty0", duty0, 32'h0);
    check("t6_busy0", 32'(busy0), 32'h0);
    check("t6_done0", 32'(done0), 32'h0);
    check("t6_duty1", duty1, 32'h0);
    rst = 1'b0;
    n0_changes = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((done0 != 4'h0) || (busy0 != 4'h0) || (duty0 != 32'h0)) n0_changes++;
    end
    check("t6_quiet_after", 32'(n0_changes), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
